// File: rtl/sprocket_cds_accumulator.sv
// Correlated-double-sample accumulator for the Sprocket ADC.
// Pairs pedestal/signal conversions, sums skip_samples differences per pixel
// with saturation, and hands each pixel result to a one-entry output register.
module sprocket_cds_accumulator #(
    parameter int ADC_WIDTH          = 12,
    parameter int ACC_WIDTH          = 24,
    parameter int PIXEL_CLUSTER_SIZE = 16,
    localparam int PIX_W = (PIXEL_CLUSTER_SIZE > 1) ? $clog2(PIXEL_CLUSTER_SIZE) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 integration,
    input  logic                 sprocket_phi1,
    input  logic                 sprocket_phi2,
    input  logic                 sprocket_eoc,
    input  logic [ADC_WIDTH-1:0] adc_data,
    input  logic [9:0]           skip_samples,
    output logic [ACC_WIDTH-1:0] pix_data,
    output logic [PIX_W-1:0]     pix_index,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic                 busy,
    output logic                 overflow,
    output logic                 overrun,
    output logic                 seq_err
);

    typedef enum logic [2:0] {
        IDLE, WAIT_PED, CONV_PED, WAIT_SIG, CONV_SIG, EMIT
    } state_t;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [PIX_W-1:0]     PIX_LAST = PIX_W'(PIXEL_CLUSTER_SIZE - 1);

    state_t                 state_q, state_d;
    logic                   eoc_s1_q, eoc_s2_q, eoc_hist_q;
    logic                   integ_q, phi1_q, phi2_q;
    logic [ADC_WIDTH-1:0]   ped_q, ped_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [9:0]             skip_cnt_q, skip_cnt_d;
    logic [9:0]             skip_lat_q, skip_lat_d;
    logic [PIX_W-1:0]       pix_cnt_q, pix_cnt_d;
    logic [ACC_WIDTH-1:0]   pix_data_q, pix_data_d;
    logic [PIX_W-1:0]       pix_index_q, pix_index_d;
    logic                   pix_valid_q, pix_valid_d;
    logic                   overflow_q, overflow_d;
    logic                   overrun_q, overrun_d;
    logic                   seq_err_q, seq_err_d;

    logic                   conv_done, integ_rise, phi1_rise, phi2_rise;
    logic signed [ADC_WIDTH:0] diff;
    logic signed [ACC_WIDTH:0] sum;
    logic                   sat_hi, sat_lo, emit_take;

    assign conv_done  = eoc_s2_q ^ eoc_hist_q;
    assign integ_rise = integration & ~integ_q;
    assign phi1_rise  = sprocket_phi1 & ~phi1_q;
    assign phi2_rise  = sprocket_phi2 & ~phi2_q;

    // Difference is one bit wider than the ADC word; the sum carries one guard bit.
    assign diff   = $signed({1'b0, adc_data}) - $signed({1'b0, ped_q});
    assign sum    = $signed({acc_q[ACC_WIDTH-1], acc_q})
                  + $signed({{(ACC_WIDTH-ADC_WIDTH){diff[ADC_WIDTH]}}, diff});
    assign sat_hi = ~sum[ACC_WIDTH] &  sum[ACC_WIDTH-1];
    assign sat_lo =  sum[ACC_WIDTH] & ~sum[ACC_WIDTH-1];

    // A restart in the EMIT cycle abandons the pixel rather than emitting it.
    assign emit_take = (state_q == EMIT) && !integ_rise;

    // State, synchroniser and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            eoc_s1_q    <= 1'b0;
            eoc_s2_q    <= 1'b0;
            eoc_hist_q  <= 1'b0;
            integ_q     <= 1'b0;
            phi1_q      <= 1'b0;
            phi2_q      <= 1'b0;
            ped_q       <= '0;
            acc_q       <= '0;
            skip_cnt_q  <= '0;
            skip_lat_q  <= '0;
            pix_cnt_q   <= '0;
            pix_data_q  <= '0;
            pix_index_q <= '0;
            pix_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            overrun_q   <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            eoc_s1_q    <= sprocket_eoc;
            eoc_s2_q    <= eoc_s1_q;
            eoc_hist_q  <= eoc_s2_q;
            integ_q     <= integration;
            phi1_q      <= sprocket_phi1;
            phi2_q      <= sprocket_phi2;
            ped_q       <= ped_d;
            acc_q       <= acc_d;
            skip_cnt_q  <= skip_cnt_d;
            skip_lat_q  <= skip_lat_d;
            pix_cnt_q   <= pix_cnt_d;
            pix_data_q  <= pix_data_d;
            pix_index_q <= pix_index_d;
            pix_valid_q <= pix_valid_d;
            overflow_q  <= overflow_d;
            overrun_q   <= overrun_d;
            seq_err_q   <= seq_err_d;
        end
    end

    // Next-state, accumulation and output-register control.
    always_comb begin
        state_d     = state_q;
        ped_d       = ped_q;
        acc_d       = acc_q;
        skip_cnt_d  = skip_cnt_q;
        skip_lat_d  = skip_lat_q;
        pix_cnt_d   = pix_cnt_q;
        pix_data_d  = pix_data_q;
        pix_index_d = pix_index_q;
        pix_valid_d = pix_valid_q;
        overflow_d  = overflow_q;
        overrun_d   = overrun_q;
        seq_err_d   = seq_err_q;

        if (pix_valid_q && pix_ready) begin
            pix_valid_d = 1'b0;
        end
        if (emit_take) begin
            if (!pix_valid_q || pix_ready) begin
                pix_data_d  = acc_q;
                pix_index_d = pix_cnt_q;
                pix_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: ;
            WAIT_PED: begin
                if (phi1_rise)      state_d = CONV_PED;
                else if (phi2_rise) seq_err_d = 1'b1;
            end
            CONV_PED: begin
                if (phi1_rise || phi2_rise) seq_err_d = 1'b1;
                if (conv_done) begin
                    ped_d   = adc_data;
                    state_d = WAIT_SIG;
                end
            end
            WAIT_SIG: begin
                if (phi2_rise)      state_d = CONV_SIG;
                else if (phi1_rise) seq_err_d = 1'b1;
            end
            CONV_SIG: begin
                if (phi1_rise || phi2_rise) seq_err_d = 1'b1;
                if (conv_done) begin
                    if (sat_hi) begin
                        acc_d      = ACC_MAX;
                        overflow_d = 1'b1;
                    end else if (sat_lo) begin
                        acc_d      = ACC_MIN;
                        overflow_d = 1'b1;
                    end else begin
                        acc_d = sum[ACC_WIDTH-1:0];
                    end
                    skip_cnt_d = skip_cnt_q + 10'd1;
                    state_d    = (skip_cnt_q + 10'd1 == skip_lat_q) ? EMIT : WAIT_PED;
                end
            end
            EMIT: begin
                acc_d      = '0;
                skip_cnt_d = '0;
                if (pix_cnt_q == PIX_LAST) begin
                    state_d = IDLE;
                end else begin
                    pix_cnt_d = pix_cnt_q + PIX_W'(1);
                    state_d   = WAIT_PED;
                end
            end
            default: state_d = IDLE;
        endcase

        // Cluster restart overrides everything except the output register.
        if (integ_rise) begin
            acc_d      = '0;
            skip_cnt_d = '0;
            pix_cnt_d  = '0;
            overflow_d = 1'b0;
            overrun_d  = 1'b0;
            seq_err_d  = 1'b0;
            skip_lat_d = (skip_samples == 10'd0) ? 10'd1 : skip_samples;
            state_d    = WAIT_PED;
        end
    end

    assign pix_data  = pix_data_q;
    assign pix_index = pix_index_q;
    assign pix_valid = pix_valid_q;
    assign busy      = (state_q != IDLE);
    assign overflow  = overflow_q;
    assign overrun   = overrun_q;
    assign seq_err   = seq_err_q;

endmodule
